// File: rtl/my_dispatch_pkg.sv
// Shared constants, state type and round-robin lane scan for the 8-way dispatcher.
package my_dispatch_pkg;

  localparam int NUM_LANES = 8;
  localparam int SEL_W     = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Rotate the mask so ptr lands on bit 0, take the lowest set bit, then rotate back.
  function automatic logic [SEL_W-1:0] next_lane(input logic [SEL_W-1:0] ptr,
                                                  input logic [NUM_LANES-1:0] mask);
    logic [2*NUM_LANES-1:0] dbl;
    logic [NUM_LANES-1:0]   rot;
    logic [SEL_W-1:0]       off;
    dbl = {mask, mask} >> ptr;
    rot = dbl[NUM_LANES-1:0];
    off = '0;
    for (int j = NUM_LANES - 1; j >= 0; j--) begin
      if (rot[j]) off = SEL_W'(j);
    end
    return ptr + off;
  endfunction

endpackage

// File: rtl/my_dmux8way.sv
// 1-to-8 demultiplexer: drives in_i onto the output bit chosen by sel_i.
module my_dmux8way (
  input  logic       in_i,
  input  logic [2:0] sel_i,
  output logic [7:0] out_o
);

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    localparam logic [2:0] IDX = gi;
    assign out_o[gi] = in_i && (sel_i == IDX);
  end

endmodule

// File: rtl/my_dispatch8way.sv
// Single-word buffer dispatching upstream words to 8 lanes in round-robin order.
// Define MY_DISPATCH_SKIP_BUSY_EN to also skip lanes whose sink is not ready.
module my_dispatch8way
  import my_dispatch_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_data,
  input  logic [NUM_LANES-1:0] lane_en,
  output logic [NUM_LANES-1:0] out_valid,
  input  logic [NUM_LANES-1:0] out_ready,
  output logic [W-1:0]         out_data,
  output logic [SEL_W-1:0]     out_sel
);

  state_e               state_q;
  logic [W-1:0]         buf_data_q;
  logic [SEL_W-1:0]     buf_sel_q;
  logic [SEL_W-1:0]     ptr_q;
  logic [SEL_W-1:0]     sel_d;
  logic [NUM_LANES-1:0] sel_mask;
  logic [NUM_LANES-1:0] dmux_out;
  logic                 accept;
  logic                 drain;

  assign drain    = (state_q == HOLD) && out_ready[buf_sel_q];
  assign in_ready = !reset && (|lane_en) && ((state_q == EMPTY) || out_ready[buf_sel_q]);
  assign accept   = in_valid && in_ready;

`ifdef MY_DISPATCH_SKIP_BUSY_EN
  logic [NUM_LANES-1:0] ready_mask;
  assign ready_mask = lane_en & out_ready;
  assign sel_mask   = (|ready_mask) ? ready_mask : lane_en;
`else
  assign sel_mask = lane_en;
`endif

  assign sel_d = next_lane(ptr_q, sel_mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      buf_data_q <= '0;
      buf_sel_q  <= '0;
      ptr_q      <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q    <= HOLD;
            buf_data_q <= in_data;
            buf_sel_q  <= sel_d;
            ptr_q      <= sel_d + SEL_W'(1);
          end
        end
        HOLD: begin
          // Drain and refill in the same cycle keeps one word per cycle flowing.
          if (accept) begin
            buf_data_q <= in_data;
            buf_sel_q  <= sel_d;
            ptr_q      <= sel_d + SEL_W'(1);
          end else if (drain) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  my_dmux8way u_dmux (
    .in_i  (state_q == HOLD),
    .sel_i (buf_sel_q),
    .out_o (dmux_out)
  );

  assign out_valid = reset ? '0 : dmux_out;
  assign out_data  = reset ? '0 : buf_data_q;
  assign out_sel   = (reset || (state_q == EMPTY)) ? '0 : buf_sel_q;

endmodule

// File: tb/tb_my_dispatch8way.sv
// Self-checking bench for my_dispatch8way: directed scenarios plus random traffic vs a lane model.
module tb_my_dispatch8way;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] lane_en;
  logic [7:0] out_valid;
  logic [7:0] out_ready;
  logic [7:0] out_data;
  logic [2:0] out_sel;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: one optional held word plus the rotation pointer.
  bit   m_full = 1'b0;
  logic [7:0] m_data = 8'h00;
  int   m_sel = 0;
  int   m_ptr = 0;

  my_dispatch8way #(.W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .lane_en   (lane_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks combinational outputs mid-cycle, then advances the model across one clock edge.
  task automatic cycle();
    logic       exp_rdy;
    logic [7:0] exp_v;
    logic [2:0] exp_s;
    logic [7:0] mask;
    int         lane;
    @(negedge clk);
    exp_rdy = !reset && (lane_en != 8'h00) && (!m_full || out_ready[m_sel]);
    exp_v   = (reset || !m_full) ? 8'h00 : 8'(1 << m_sel);
    exp_s   = (reset || !m_full) ? 3'd0 : 3'(m_sel);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("out_valid", {24'd0, out_valid}, {24'd0, exp_v});
    chk("out_sel", {29'd0, out_sel}, {29'd0, exp_s});
    if (reset) chk("out_data_rst", {24'd0, out_data}, 32'd0);
    else if (m_full) chk("out_data", {24'd0, out_data}, {24'd0, m_data});
    @(posedge clk);
    if (reset) begin
      m_full = 1'b0; m_ptr = 0; m_sel = 0; m_data = 8'h00;
    end else if (in_valid && exp_rdy) begin
      mask = lane_en;
`ifdef MY_DISPATCH_SKIP_BUSY_EN
      if ((lane_en & out_ready) != 8'h00) mask = lane_en & out_ready;
`endif
      lane = -1;
      for (int k = 0; k < 8; k++) begin
        if (lane < 0 && mask[(m_ptr + k) % 8]) lane = (m_ptr + k) % 8;
      end
      m_full = 1'b1;
      m_data = in_data;
      m_sel  = lane;
      m_ptr  = (lane + 1) % 8;
      $display("accept data=%02h lane=%0d", in_data, lane);
    end else if (m_full && out_ready[m_sel]) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; lane_en = 8'h00; out_ready = 8'h00;

    // Reset state
    do_reset();
    chk("rst_out_valid", {24'd0, out_valid}, 32'd0);
    chk("rst_out_sel", {29'd0, out_sel}, 32'd0);

    // Full rotation over all lanes
    lane_en = 8'hFF; out_ready = 8'hFF; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(i + 1);
      #1 chk("r030_rdy", {31'd0, in_ready}, 32'd1);
      cycle();
      chk("r030_sel", {29'd0, out_sel}, 32'(i % 8));
      chk("r030_data", {24'd0, out_data}, 32'(i + 1));
    end

    // Sparse enable mask
    do_reset();
    lane_en = 8'b1010_0100; out_ready = 8'hFF; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [2:0] lanes [3];
      lanes = '{3'd2, 3'd5, 3'd7};
      in_data = 8'(8'h40 + i);
      cycle();
      chk("r031_sel", {29'd0, out_sel}, {29'd0, lanes[i % 3]});
    end

    // Stall on a busy lane, then drain with same-cycle refill
    do_reset();
    lane_en = 8'h08; out_ready = 8'hFF; in_valid = 1'b1; in_data = 8'hA5;
    cycle();
    out_ready = 8'hF7; in_data = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("r032_valid", {24'd0, out_valid}, 32'h08);
      chk("r032_data", {24'd0, out_data}, 32'hA5);
      chk("r032_rdy", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 8'hFF;
    #1 chk("r032_rdy_drain", {31'd0, in_ready}, 32'd1);
    cycle();
    chk("r032_next", {24'd0, out_data}, 32'h5A);
    chk("r032_next_sel", {29'd0, out_sel}, 32'd3);

    // Busy-lane handling at selection time
    do_reset();
    lane_en = 8'hFF; out_ready = 8'b0000_0110; in_valid = 1'b1; in_data = 8'h33;
    cycle();
`ifdef MY_DISPATCH_SKIP_BUSY_EN
    chk("r033_sel", {29'd0, out_sel}, 32'd1);
    in_data = 8'h44;
    cycle();
    chk("r033_ptr", {29'd0, out_sel}, 32'd2);
`else
    chk("r033_sel", {29'd0, out_sel}, 32'd0);
    in_data = 8'h44;
    #1 chk("r033_stall", {31'd0, in_ready}, 32'd0);
    cycle();
    cycle();
    chk("r033_hold", {24'd0, out_valid}, 32'h01);
    out_ready = 8'hFF;
    cycle();
    chk("r033_after", {29'd0, out_sel}, 32'd1);
`endif

    // Reset while holding a word on lane 6
    do_reset();
    lane_en = 8'h40; out_ready = 8'h00; in_valid = 1'b1; in_data = 8'h66;
    cycle();
    chk("r034_hold", {24'd0, out_valid}, 32'h40);
    reset = 1'b1;
    #1 chk("r034_rdy", {31'd0, in_ready}, 32'd0);
    chk("r034_valid", {24'd0, out_valid}, 32'd0);
    cycle();
    reset = 1'b0; lane_en = 8'hFF; out_ready = 8'hFF; in_data = 8'h67;
    #1 chk("r034_empty", {24'd0, out_valid}, 32'd0);
    cycle();
    chk("r034_first", {29'd0, out_sel}, 32'd0);

    // No lanes enabled, then a single lane
    do_reset();
    lane_en = 8'h00; out_ready = 8'hFF; in_valid = 1'b1; in_data = 8'h77;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("r035_rdy", {31'd0, in_ready}, 32'd0);
    end
    lane_en = 8'h10;
    cycle();
    chk("r035_sel", {29'd0, out_sel}, 32'd4);
    chk("r035_valid", {24'd0, out_valid}, 32'h10);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      lane_en   = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      out_ready = 8'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/my_dispatch8way.md
MY_DISPATCH8WAY -- requirements
Module: my_dispatch8way

Interface
REQ-001 Parameter: W, 8, data width in bits.
REQ-002 Ports: clk  input  1  rising-edge clock for all state.
REQ-003 Ports: reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
REQ-004 Ports: in_valid  input  1  upstream word present.
REQ-005 Ports: in_ready  output  1  block accepts upstream word this cycle.
REQ-006 Ports: in_data  input  W  upstream word.
REQ-007 Ports: lane_en  input  8  per-lane enable mask; disabled lanes never selected.
REQ-008 Ports: out_valid  output  8  one-hot; bit i = held word offered to lane i.
REQ-009 Ports: out_ready  input  8  per-lane sink ready.
REQ-010 Ports: out_data  output  W  held word, broadcast to all lanes.
REQ-011 Ports: out_sel  output  3  lane index of held word; 0 when empty.

Function
REQ-012 Block SHALL hold at most one word (buffer: buf_valid, buf_data, buf_sel) and keep a 3-bit round-robin pointer ptr.
REQ-013 States SHALL be EMPTY (buf_valid=0) and HOLD (buf_valid=1); no other states.
REQ-014 in_ready SHALL equal (|lane_en) && (EMPTY || out_ready[buf_sel]), combinational, no added latency.
REQ-015 Accept = in_valid && in_ready; on accept next cycle buf_data=in_data, buf_sel=chosen lane, state=HOLD.
REQ-016 Drain = HOLD && out_ready[buf_sel]; drain without accept -> EMPTY; drain with accept -> stays HOLD with new word (back-to-back, one word/cycle).
REQ-017 Latency: word accepted in cycle N SHALL appear on out_valid/out_data in cycle N+1.
REQ-018 Chosen lane: first enabled index scanning ptr, ptr+1, ... mod 8 (wrap 7->0); ptr updates to chosen+1 mod 8 on accept only.
REQ-019 out_valid SHALL be buf_valid decoded by buf_sel; all zero in EMPTY.
REQ-020 out_data and out_sel SHALL be stable while HOLD without drain.
REQ-021 lane_en change during HOLD SHALL NOT move or drop the held word; it affects only later selections.
REQ-022 lane_en == 0: in_ready=0; held word still drains normally.
REQ-023 in_valid without in_ready SHALL leave ptr and buffer unchanged.

Reset
REQ-024 reset SHALL force state=EMPTY, ptr=0, buf_sel=0, buf_data=0 at next clk edge, discarding any held word.
REQ-025 During reset cycle in_ready=0, out_valid=0, out_data=0, out_sel=0.

Configuration
REQ-026 Macro MY_DISPATCH_SKIP_BUSY_EN defined: selection (REQ-018) SHALL also skip lanes with out_ready=0 at accept time; if no enabled lane is ready, fall back to REQ-018 rule.
REQ-027 Macro undefined: selection SHALL use lane_en only (strict rotation over enabled lanes), ignoring out_ready.

Structure
REQ-028 Package my_dispatch_pkg SHALL hold NUM_LANES=8, SEL_W=3, state enum {EMPTY, HOLD}, and the next-lane scan function.
REQ-029 out_valid decode SHALL instantiate existing my_dmux8way (in=buf_valid, sel=buf_sel); no other sub-modules.

Verification
REQ-030 Reset then lane_en=8'hFF, out_ready=8'hFF, in_valid=1 for 10 cycles, data 1..10 -> lanes 0,1,..,7,0,1 one per cycle; out_sel matches; in_ready stays 1.
REQ-031 lane_en=8'b1010_0100, 6 words -> lanes 2,5,7,2,5,7.
REQ-032 Word 8'hA5 to lane 3, out_ready[3]=0 for 4 cycles -> out_valid=8'h08 and out_data=8'hA5 held, in_ready=0; out_ready[3]=1 -> drains, next word accepted same cycle.
REQ-033 SKIP_BUSY_EN defined, ptr=0, out_ready=8'b0000_0110 -> next word to lane 1, ptr=2; undefined -> lane 0 and stall until out_ready[0].
REQ-034 reset asserted while HOLD on lane 6 -> next cycle out_valid=0, in_ready=0 during reset; after release first word goes to lane 0.
REQ-035 lane_en=0 with in_valid=1 -> in_ready=0 indefinitely; lane_en=8'h10 -> word goes to lane 4.
